// File: rtl/sub_bytes_serial.sv
`default_nettype none
// ============================================================================
// Module   : sub_bytes_serial (with combinational s_box)
// Purpose  : Serial AES SubBytes over a 128-bit state, BYTES_PER_CYCLE S-boxes.
//            Optional fused ShiftRows when SUB_BYTES_SHIFTROWS_EN is defined.
// Revision : 1.0  initial release
// ============================================================================

module s_box (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);
    // Entry x lives at bits [8*(255-x) +: 8]; 255-x is simply ~x.
    localparam logic [2047:0] c_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign out_byte = c_SBOX[{~in_byte, 3'b000} +: 8];
endmodule

module sub_bytes_serial #(
    parameter int BYTES_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out,
    output logic         busy
);
    localparam logic [4:0] c_STEP = 5'(BYTES_PER_CYCLE);
    localparam logic [4:0] c_LAST = 5'd16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       r_state;
    logic [4:0]   r_cnt;
    logic [127:0] r_block;
    logic [127:0] r_state_out;
    logic         r_in_ready;
    logic         r_out_valid;
    logic         r_busy;

    logic [4:0]   w_cnt_next;
    logic [3:0]   w_dst   [BYTES_PER_CYCLE];
    logic [3:0]   w_src   [BYTES_PER_CYCLE];
    logic [7:0]   w_sb_in [BYTES_PER_CYCLE];
    logic [7:0]   w_sb_out[BYTES_PER_CYCLE];

    assign w_cnt_next = r_cnt + c_STEP;

    generate
        for (genvar k = 0; k < BYTES_PER_CYCLE; k++) begin : g_lane
            // Lane k writes output byte cnt+k; the source byte depends on ShiftRows.
            assign w_dst[k] = r_cnt[3:0] + 4'(k);
`ifdef SUB_BYTES_SHIFTROWS_EN
            // out (r,c) takes in (r,(c+r) mod 4): byte index = r + 4*((c+r) mod 4)
            assign w_src[k] = {w_dst[k][3:2] + w_dst[k][1:0], w_dst[k][1:0]};
`else
            assign w_src[k] = w_dst[k];
`endif
            assign w_sb_in[k] = r_block[{~w_src[k], 3'b000} +: 8];

            s_box u_s_box (
                .in_byte  (w_sb_in[k]),
                .out_byte (w_sb_out[k])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_block     <= '0;
            r_state_out <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_block    <= state_in;
                        r_cnt      <= '0;
                        r_state    <= RUN;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                RUN: begin
                    for (int k = 0; k < BYTES_PER_CYCLE; k++) begin
                        r_state_out[{~w_dst[k], 3'b000} +: 8] <= w_sb_out[k];
                    end
                    r_cnt <= w_cnt_next;
                    if (w_cnt_next == c_LAST) begin
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign state_out = r_state_out;
endmodule

`default_nettype wire
